// File: rtl/vga_fetch_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fetch_shifter
//  Purpose  : Fetches DATA_W-bit VRAM words over a request/acknowledge
//             handshake and shifts them out MSB-first as 1-bit pixels. One
//             word is buffered ahead of the shifter so fetch latency is
//             hidden. Word 0 of the next line is prefetched during
//             horizontal blanking. Underruns are flagged stickily.
//  Ports    : pixClock    - pixel clock, rising-edge active
//             nReset      - asynchronous active-low reset
//             vCount      - current line index from the timing generator
//             hSEActive   - horizontal active window
//             vSEActive   - vertical active window
//             invert      - invert active pixels
//             vramData    - VRAM read data, valid while vramAck=1
//             vramAck     - arbiter grant / data-valid strobe
//             vramReq     - read request, held until acknowledged
//             vramAddr    - word address of the outstanding request
//             vidOut      - registered pixel output
//             underrun    - sticky underrun flag
//             clrUnderrun - synchronous clear of underrun (set wins)
//  Revision : 1.0 - initial release
// ============================================================================
module vga_fetch_shifter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 15,
    parameter int LINE_WORDS = 64,
    parameter int V_LINES    = 342,
    parameter int BASE_ADDR  = 0
) (
    input  logic              pixClock,
    input  logic              nReset,
    input  logic [9:0]        vCount,
    input  logic              hSEActive,
    input  logic              vSEActive,
    input  logic              invert,
    input  logic [DATA_W-1:0] vramData,
    input  logic              vramAck,
    output logic              vramReq,
    output logic [ADDR_W-1:0] vramAddr,
    output logic              vidOut,
    output logic              underrun,
    input  logic              clrUnderrun
);

    // Word indices run 0..LINE_WORDS; the value LINE_WORDS means "line done".
    localparam int IDX_W = $clog2(LINE_WORDS) + 1;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int ROW_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;

    localparam logic [IDX_W-1:0]  C_LW_IDX  = IDX_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0]  C_LAST    = CNT_W'(DATA_W - 1);
    localparam logic [10:0]       C_VLINES  = 11'(V_LINES);
    localparam logic [ADDR_W-1:0] C_BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] C_LW_ADDR = ADDR_W'(LINE_WORDS);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [0:0]        r_state, w_stateNext;
    logic              r_actD;
    logic              r_hv;
    logic              r_stale;
    logic [IDX_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_buf;
    logic [DATA_W-1:0] r_shift;
    logic [IDX_W-1:0]  r_fetchIdx;
    logic [IDX_W-1:0]  r_slotIdx;
    logic [CNT_W-1:0]  r_bitCnt;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_vramAddr;
    logic              r_vidOut;
    logic              r_underrun;

    logic              w_vidActive, w_lineEnd, w_slotStart, w_tagHit;
    logic              w_under, w_ack, w_keep, w_launch;
    logic [10:0]       w_vNext;
    logic [ROW_W-1:0]  w_rowNext;
    logic [IDX_W-1:0]  w_fetchNext, w_slotInc;
    logic              w_hvNext;
    logic [ADDR_W-1:0] w_addrNext;

    assign w_vidActive = hSEActive & vSEActive;
    assign w_lineEnd   = r_actD & ~w_vidActive;
    assign w_slotStart = w_vidActive & (r_bitCnt == '0);
    assign w_tagHit    = r_hv & (r_tag == r_slotIdx);
    assign w_under     = w_slotStart & ~w_tagHit;
    assign w_ack       = (r_state == S_REQ) & vramAck;
    // A word requested before a line end belongs to the old row: drop it.
    assign w_keep      = w_ack & ~r_stale & ~w_lineEnd;
    assign w_vNext     = {1'b0, vCount} + 11'd1;
    // Slot index saturates at LINE_WORDS so overrun slots never match a tag.
    assign w_slotInc   = (r_slotIdx == C_LW_IDX) ? C_LW_IDX : r_slotIdx + IDX_W'(1);

    always_comb begin
        w_rowNext = r_row;
        if (!vSEActive) begin
            w_rowNext = '0;
        end else if (w_lineEnd) begin
            w_rowNext = (w_vNext >= C_VLINES) ? '0 : ROW_W'(w_vNext);
        end
    end

    always_comb begin
        w_fetchNext = r_fetchIdx;
        if (w_lineEnd) begin
            w_fetchNext = '0;
        end else if (w_keep) begin
            w_fetchNext = r_fetchIdx + IDX_W'(1);
        end else if (w_under && (r_state == S_IDLE) && (r_fetchIdx <= r_slotIdx)) begin
            // Skip words whose slot has already gone by.
            w_fetchNext = w_slotInc;
        end
    end

    always_comb begin
        w_hvNext = r_hv;
        if (w_lineEnd) begin
            w_hvNext = 1'b0;
        end else if (w_keep) begin
            w_hvNext = 1'b1;
        end else if (w_slotStart && w_tagHit) begin
            w_hvNext = 1'b0;
        end else if (w_under && r_hv && (r_tag < r_slotIdx)) begin
            w_hvNext = 1'b0;
        end
    end

    // Launch decisions look at the post-edge buffer/index/row so a slot
    // consumed, a skip or a line end on this edge is followed immediately.
    assign w_launch   = (r_state == S_IDLE) & ~w_hvNext & (w_fetchNext < C_LW_IDX);
    assign w_addrNext = C_BASE + ADDR_W'(w_rowNext) * C_LW_ADDR + ADDR_W'(w_fetchNext);

    // ---------------- fetch FSM ----------------
    always_ff @(posedge pixClock or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_stateNext = S_REQ;
            S_REQ:   if (vramAck)  w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_comb begin
        vramReq = 1'b0;
        case (r_state)
            S_REQ:   vramReq = 1'b1;
            default: vramReq = 1'b0;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge pixClock or negedge nReset) begin
        if (!nReset) begin
            r_actD     <= 1'b0;
            r_hv       <= 1'b0;
            r_stale    <= 1'b0;
            r_tag      <= '0;
            r_buf      <= '0;
            r_shift    <= '0;
            r_fetchIdx <= '0;
            r_slotIdx  <= '0;
            r_bitCnt   <= '0;
            r_row      <= '0;
            r_vramAddr <= C_BASE;
            r_vidOut   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_actD     <= w_vidActive;
            r_row      <= w_rowNext;
            r_fetchIdx <= w_fetchNext;
            r_hv       <= w_hvNext;

            if (w_keep) begin
                r_tag <= r_fetchIdx;
                r_buf <= vramData;
            end

            if (w_ack) begin
                r_stale <= 1'b0;
            end else if (w_lineEnd && (r_state == S_REQ)) begin
                r_stale <= 1'b1;
            end

            if (w_launch) begin
                r_vramAddr <= w_addrNext;
            end

            if (!w_vidActive) begin
                r_vidOut <= 1'b0;
                if (w_lineEnd) begin
                    r_bitCnt  <= '0;
                    r_slotIdx <= '0;
                end
            end else if (w_slotStart) begin
                r_bitCnt  <= C_LAST;
                r_slotIdx <= w_slotInc;
                if (w_tagHit) begin
                    r_vidOut <= r_buf[DATA_W-1] ^ invert;
                    r_shift  <= {r_buf[DATA_W-2:0], 1'b0};
                end else begin
                    r_vidOut <= invert;
                    r_shift  <= '0;
                end
            end else begin
                r_vidOut <= r_shift[DATA_W-1] ^ invert;
                r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
                r_bitCnt <= r_bitCnt - CNT_W'(1);
            end

            if (w_under) begin
                r_underrun <= 1'b1;
            end else if (clrUnderrun) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign vramAddr = r_vramAddr;
    assign vidOut   = r_vidOut;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_vga_fetch_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_fetch_shifter
//  Purpose  : Self-checking bench for vga_fetch_shifter. A behavioural model
//             (pixel k of a line comes from slot k/DATA_W, bit k%DATA_W)
//             is compared against the DUT every cycle; directed scenarios
//             pin the model with hand-computed literal expectations, then
//             randomized lines exercise ack timing, overrun and clears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fetch_shifter;

    localparam int DW   = 8;
    localparam int AW   = 15;
    localparam int LW   = 64;
    localparam int VL   = 342;
    localparam int BASE = 0;

    logic          pixClock = 1'b0;
    logic          nReset;
    logic [9:0]    vCount;
    logic          hSEActive, vSEActive, invert;
    logic [DW-1:0] vramData;
    logic          vramAck;
    logic          vramReq;
    logic [AW-1:0] vramAddr;
    logic          vidOut, underrun, clrUnderrun;

    vga_fetch_shifter #(
        .DATA_W(DW), .ADDR_W(AW), .LINE_WORDS(LW), .V_LINES(VL), .BASE_ADDR(BASE)
    ) dut (
        .pixClock(pixClock), .nReset(nReset), .vCount(vCount),
        .hSEActive(hSEActive), .vSEActive(vSEActive), .invert(invert),
        .vramData(vramData), .vramAck(vramAck), .vramReq(vramReq),
        .vramAddr(vramAddr), .vidOut(vidOut), .underrun(underrun),
        .clrUnderrun(clrUnderrun)
    );

    always #5 pixClock = ~pixClock;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int nChecks = 0;
    int nErrors = 0;
    bit cmpEn = 0;

    // stimulus control for the acknowledge side
    int ackMode  = 0;   // 0 never, 1 always, 2 after ackDelay cycles, 3 random
    int ackDelay = 0;
    int reqAge   = 0;

    // behavioural model state (values visible after the latest edge)
    bit            mReq, mVid, mUnder, mHave, mStale, mPrevAct;
    int            mAddr, mTag, mFetch, mRow, mK;
    logic [DW-1:0] mWord, mSlotWord;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mReq = 0; mVid = 0; mUnder = 0; mHave = 0; mStale = 0; mPrevAct = 0;
        mAddr = BASE; mTag = 0; mFetch = 0; mRow = 0; mK = 0;
        mWord = '0; mSlotWord = '0;
    endtask

    task automatic modelStep();
        bit act, lineEnd, ackNow, underSet, nHave, nReq, nVid;
        int nFetch, nRow, s, p;
        act = hSEActive && vSEActive;
        lineEnd = mPrevAct && !act;
        ackNow = mReq && vramAck;
        nHave = mHave; nFetch = mFetch; nReq = mReq; nRow = mRow;
        underSet = 0; nVid = 0;
        if (act) begin
            s = mK / DW;
            p = mK % DW;
            if (p == 0) begin
                if (mHave && mTag == s) begin
                    mSlotWord = mWord;
                    nHave = 0;
                end else begin
                    mSlotWord = '0;
                    underSet = 1;
                    if (mHave && mTag < s) nHave = 0;
                    if (!mReq && mFetch <= s) nFetch = (s + 1 < LW) ? s + 1 : LW;
                end
            end
            nVid = mSlotWord[DW-1-p] ^ invert;
            mK++;
        end
        if (ackNow) begin
            nReq = 0;
            if (!mStale && !lineEnd) begin
                nHave = 1;
                mTag = mFetch;
                mWord = vramData;
                nFetch = mFetch + 1;
            end
            mStale = 0;
        end
        if (lineEnd) begin
            nFetch = 0;
            nHave = 0;
            mK = 0;
            if (mReq && !ackNow) mStale = 1;
        end
        if (!vSEActive) nRow = 0;
        else if (lineEnd) nRow = (int'(vCount) + 1 >= VL) ? 0 : int'(vCount) + 1;
        if (!mReq && !nHave && nFetch < LW) begin
            nReq = 1;
            mAddr = (BASE + nRow * LW + nFetch) % (1 << AW);
        end
        if (underSet) mUnder = 1;
        else if (clrUnderrun) mUnder = 0;
        mHave = nHave; mFetch = nFetch; mReq = nReq; mRow = nRow;
        mVid = nVid; mPrevAct = act;
    endtask

    task automatic driveAck();
        if (mReq && nReset) reqAge++;
        else reqAge = 0;
        case (ackMode)
            0:       vramAck = 1'b0;
            1:       vramAck = 1'b1;
            2:       vramAck = mReq && (reqAge > ackDelay);
            default: vramAck = ($urandom_range(0, 2) == 0);
        endcase
        vramData = (vramAck && mReq) ? mem[mAddr] : DW'($urandom);
    endtask

    // one clock: inputs are already set; model advances for the coming edge
    task automatic tick();
        driveAck();
        if (!nReset) modelReset();
        else modelStep();
        @(posedge pixClock);
        @(negedge pixClock);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // single compare process against the model
    always @(negedge pixClock) begin
        if (cmpEn) begin
            check("vramReq",  32'(vramReq),  32'(mReq));
            check("vramAddr", 32'(vramAddr), 32'(mAddr));
            check("vidOut",   32'(vidOut),   32'(mVid));
            check("underrun", 32'(underrun), 32'(mUnder));
        end
    end

    initial begin
        logic [15:0] patA;
        logic [7:0]  patB;
        int seq;
        bit found;

        patA = 16'hA53C;
        patB = 8'b0101_1010;
        for (int i = 0; i < (1 << AW); i++) begin
            if (i % LW == 0)      mem[i] = 8'hA5;
            else if (i % LW == 1) mem[i] = 8'h3C;
            else                  mem[i] = DW'($urandom);
        end

        nReset = 0; vCount = '0; hSEActive = 0; vSEActive = 1; invert = 0;
        vramAck = 0; vramData = '0; clrUnderrun = 0;
        modelReset();
        @(negedge pixClock);
        #1;
        check("rstReq",   32'(vramReq),  32'd0);
        check("rstAddr",  32'(vramAddr), 32'(BASE));
        check("rstVid",   32'(vidOut),   32'd0);
        check("rstUnder", 32'(underrun), 32'd0);
        cmpEn = 1;
        run(2);
        nReset = 1;

        // ---- row 0: A5, 3C with ack tied high ----
        ackMode = 1; seq = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (vramReq && seq < LW) begin check("addrSeq", 32'(vramAddr), 32'(seq)); seq++; end
        end
        hSEActive = 1;
        for (int i = 0; i < LW * DW; i++) begin
            tick();
            if (i < 16) check("pixA", 32'(vidOut), 32'(patA[15-i]));
            if (vramReq && seq < LW) begin check("addrSeq", 32'(vramAddr), 32'(seq)); seq++; end
        end
        check("noUnderA", 32'(underrun), 32'd0);
        hSEActive = 0;
        tick();
        ackMode = 0;
        run(3);
        check("nextRowReq",  32'(vramReq),  32'd1);
        check("nextRowAddr", 32'(vramAddr), 32'(BASE + LW));

        // ---- row 1 inverted, line end at the last line ----
        ackMode = 1; invert = 1; vCount = 10'd1;
        run(5);
        hSEActive = 1;
        for (int i = 0; i < LW * DW; i++) begin
            tick();
            if (i < 8) check("pixInv", 32'(vidOut), 32'(patB[7-i]));
        end
        vCount = 10'(VL - 1);
        hSEActive = 0;
        tick();
        check("blankInv", 32'(vidOut), 32'd0);
        ackMode = 0;
        run(3);
        check("wrapAddr", 32'(vramAddr), 32'(BASE));

        // ---- short line ending at vCount=5 ----
        ackMode = 1; invert = 0; vCount = 10'd5;
        run(5);
        hSEActive = 1;
        run(40);
        hSEActive = 0;
        tick();
        ackMode = 0;
        run(3);
        check("row6Addr", 32'(vramAddr), 32'(BASE + 6 * LW));

        // ---- slow arbiter: 20-cycle ack delay ----
        ackMode = 2; ackDelay = 20;
        run(30);
        hSEActive = 1;
        run(24);
        check("underBySlot2", 32'(underrun), 32'd1);
        run(LW * DW - 24);
        vCount = 10'd6;
        hSEActive = 0;
        run(30);

        // ---- clear ----
        ackMode = 0; clrUnderrun = 1;
        tick();
        check("clrUnder", 32'(underrun), 32'd0);
        clrUnderrun = 0;

        // ---- asynchronous reset mid-word with a request outstanding ----
        ackMode = 2; ackDelay = 20; vCount = 10'd7; hSEActive = 1;
        found = 0;
        for (int n = 0; n < 60 && !found; n++) begin
            tick();
            if (n >= 3 && mReq && (mK % DW) != 0) found = 1;
        end
        if (!found) begin
            nChecks++; nErrors++;
            $display("FAIL findMidWord: got 0, expected 1 (no outstanding request within bound)");
        end
        driveAck();
        modelStep();
        @(posedge pixClock);
        #2 nReset = 0;
        #1;
        check("asyncReq",   32'(vramReq),  32'd0);
        check("asyncAddr",  32'(vramAddr), 32'(BASE));
        check("asyncVid",   32'(vidOut),   32'd0);
        check("asyncUnder", 32'(underrun), 32'd0);
        modelReset();
        @(negedge pixClock);
        #1;
        hSEActive = 0; ackMode = 1;
        run(3);
        nReset = 1; ackMode = 0;
        tick();
        check("postRstReq",  32'(vramReq),  32'd1);
        check("postRstAddr", 32'(vramAddr), 32'(BASE));

        // ---- set wins over clear ----
        hSEActive = 1; clrUnderrun = 1;
        tick();
        check("setDominant", 32'(underrun), 32'd1);
        clrUnderrun = 0;
        run(3);
        hSEActive = 0;
        run(2);

        // ---- randomized lines ----
        for (int line = 0; line < 40; line++) begin
            int blank, actLen, v;
            ackMode  = $urandom_range(1, 3);
            ackDelay = $urandom_range(0, 12);
            invert   = 1'($urandom_range(0, 1));
            blank    = $urandom_range(2, 40);
            vSEActive = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < blank; i++) begin
                clrUnderrun = ($urandom_range(0, 15) == 0);
                tick();
            end
            v = ($urandom_range(0, 3) == 0) ? VL - 1 : $urandom_range(0, VL - 1);
            vCount = 10'(v);
            vSEActive = 1;
            hSEActive = 1;
            actLen = $urandom_range(100, 600);
            for (int i = 0; i < actLen; i++) begin
                clrUnderrun = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 63) == 0) invert = ~invert;
                tick();
            end
            hSEActive = 0;
        end
        clrUnderrun = 0;
        run(5);

        cmpEn = 0;
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
